// File: rtl/cmos_pkg.sv
// Shared types and default geometry for the CMOS camera capture path.
// Sized for an 800x480 RGB565 sensor stream.
package cmos_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SKIP      = 2'd1,
    ACTIVE    = 2'd2
  } cap_state_t;

  localparam int DEF_IMG_WIDTH  = 800;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int DEF_FRAME_WAIT = 10;

endpackage

// File: rtl/cmos_sync_edge.sv
// Single register stage for a sensor strobe, with rise/fall pulses
// derived from the registered copy.
module cmos_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= d;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/cmos_pixel_packer.sv
// Packs CMOS sensor byte pairs into RGB565 pixels, skips settling
// frames and flags frames whose geometry is wrong.
module cmos_pixel_packer
  import cmos_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int FRAME_WAIT = DEF_FRAME_WAIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_din,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        frame_err
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int PW    = $clog2(TOTAL + 1);
  localparam int CW    = $clog2(IMG_WIDTH + 2);
  localparam int SW    = $clog2(FRAME_WAIT + 2);
  localparam int SKIP_LAST = (FRAME_WAIT > 0) ? FRAME_WAIT - 1 : 0;

  localparam logic [PW-1:0] TOTAL_C  = PW'(TOTAL);
  localparam logic [CW-1:0] WIDTH_C  = CW'(IMG_WIDTH);
  localparam logic [CW-1:0] COL_SAT  = CW'(IMG_WIDTH + 1);
  localparam logic [SW-1:0] SKIP_MAX = SW'(SKIP_LAST);

  logic vsync_q, fe, fb;
  logic href_q, href_rise, href_fall;
  logic [7:0] din_q;

  cap_state_t state, state_nxt;

  logic [SW-1:0] skip_cnt;
  logic [PW-1:0] pix_cnt;
  logic [CW-1:0] col_cnt;
  logic          phase;
  logic [7:0]    held;
  logic          frame_open;

  logic active, start_evt, byte_en, pix_done;
  logic pix_ok, pix_over, line_bad, done_evt;

  cmos_sync_edge u_vsync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmos_vsync),
    .q     (vsync_q),
    .rise  (fe),
    .fall  (fb)
  );

  cmos_sync_edge u_href (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmos_href),
    .q     (href_q),
    .rise  (href_rise),
    .fall  (href_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_q <= 8'd0;
    else        din_q <= cmos_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_SYNC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = WAIT_SYNC;
    end else begin
      unique case (state)
        WAIT_SYNC:
          if (fb) state_nxt = (FRAME_WAIT == 0) ? ACTIVE : SKIP;
        SKIP:
          if (fb && skip_cnt == SKIP_MAX) state_nxt = ACTIVE;
        ACTIVE:
          state_nxt = ACTIVE;
        default:
          state_nxt = WAIT_SYNC;
      endcase
    end
  end

  // A pixel finishing on the fb cycle is left over from blanking.
  always_comb begin
    active    = en && (state == ACTIVE);
    start_evt = fb && (state_nxt == ACTIVE);
    byte_en   = href_q && !vsync_q;
    pix_done  = byte_en && phase && !fb;
    pix_ok    = active && pix_done && (pix_cnt != TOTAL_C);
    pix_over  = active && pix_done && (pix_cnt == TOTAL_C);
    line_bad  = active && href_fall && !vsync_q &&
                (phase || col_cnt != WIDTH_C);
    done_evt  = active && fe && frame_open;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt <= '0;
    end else if (!en || state != SKIP) begin
      skip_cnt <= '0;
    end else if (fb) begin
      skip_cnt <= skip_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      held  <= 8'd0;
    end else begin
      if (start_evt || !href_q) phase <= 1'b0;
      else if (!vsync_q)        phase <= ~phase;
      if (byte_en && !phase)    held  <= din_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt    <= '0;
      col_cnt    <= '0;
      frame_open <= 1'b0;
    end else begin
      if (start_evt)   pix_cnt <= '0;
      else if (pix_ok) pix_cnt <= pix_cnt + PW'(1);
      if (start_evt || href_rise)
        col_cnt <= '0;
      else if (pix_done && col_cnt != COL_SAT)
        col_cnt <= col_cnt + CW'(1);
      if (start_evt)         frame_open <= 1'b1;
      else if (!active || fe) frame_open <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_data    <= 16'd0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      pix_valid   <= pix_ok;
      frame_start <= start_evt;
      frame_done  <= done_evt;
      if (pix_ok)
        pix_data <= {held, din_q};
      if (done_evt)
        frame_ok <= (pix_cnt == TOTAL_C) && !frame_err;
      if (start_evt)
        frame_err <= 1'b0;
      else if (pix_over || line_bad)
        frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Directed bench: 4x2 frames, two settling frames (dut0) and none (dut1).
module tb_cmos_pixel_packer;

  logic        clk = 1'b0;
  logic        rst_n, en, vs, hr;
  logic [7:0]  din;

  logic [15:0] pd0, pd1;
  logic        pv0_o, fs0_o, fd0_o, fok0, ferr0;
  logic        pv1_o, fs1_o, fd1_o, fok1, ferr1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int pv0 = 0, fs0 = 0, fd0 = 0;
  int pv1 = 0, fs1 = 0, fd1 = 0;
  logic ok_d = 1'b0, err_d = 1'b0;
  logic [15:0] log0 [512];
  int          lcyc [512];
  logic [15:0] log1 [512];

  logic [7:0] bval;
  int b2_cyc = -1;

  cmos_pixel_packer #(
    .IMG_WIDTH(4), .IMG_HEIGHT(2), .FRAME_WAIT(2)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cmos_vsync(vs), .cmos_href(hr), .cmos_din(din),
    .pix_data(pd0), .pix_valid(pv0_o),
    .frame_start(fs0_o), .frame_done(fd0_o),
    .frame_ok(fok0), .frame_err(ferr0)
  );

  cmos_pixel_packer #(
    .IMG_WIDTH(4), .IMG_HEIGHT(2), .FRAME_WAIT(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cmos_vsync(vs), .cmos_href(hr), .cmos_din(din),
    .pix_data(pd1), .pix_valid(pv1_o),
    .frame_start(fs1_o), .frame_done(fd1_o),
    .frame_ok(fok1), .frame_err(ferr1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (pv0_o) begin
      if (pv0 < 512) begin
        log0[pv0] = pd0;
        lcyc[pv0] = cyc;
      end
      pv0++;
    end
    if (fs0_o) fs0++;
    if (fd0_o) begin
      fd0++;
      ok_d  = fok0;
      err_d = ferr0;
    end
    if (pv1_o) begin
      if (pv1 < 512) log1[pv1] = pd1;
      pv1++;
    end
    if (fs1_o) fs1++;
    if (fd1_o) fd1++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_line(input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      hr  = 1'b1;
      din = bval;
      if (bval == 8'd2 && b2_cyc < 0) b2_cyc = cyc;
      if (i == drop_at) en = 1'b0;
      bval = bval + 8'd1;
    end
    @(posedge clk); #1;
    hr  = 1'b0;
    din = 8'd0;
  endtask

  task automatic open_frame();
    @(posedge clk); #1;
    vs   = 1'b0;
    bval = 8'd1;
    idle(2);
  endtask

  task automatic close_frame();
    idle(2);
    @(posedge clk); #1;
    vs = 1'b1;
    idle(4);
  endtask

  task automatic drive_frame(input int l1, input int l2, input int drop_at);
    open_frame();
    send_line(l1, drop_at);
    idle(3);
    send_line(l2, -1);
    close_frame();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp += 7;
    if (pd0 !== 16'h0) begin
      n_bad++; $display("FAIL rst_pix_data: got %h want 0000", pd0);
    end
    if (pv0_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_pix_valid: got %b want 0", pv0_o);
    end
    if (fs0_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_frame_start: got %b want 0", fs0_o);
    end
    if (fd0_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_frame_done: got %b want 0", fd0_o);
    end
    if (fok0 !== 1'b0) begin
      n_bad++; $display("FAIL rst_frame_ok: got %b want 0", fok0);
    end
    if (ferr0 !== 1'b0) begin
      n_bad++; $display("FAIL rst_frame_err: got %b want 0", ferr0);
    end
    if (pv1_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_pix_valid1: got %b want 0", pv1_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    en    = 1'b1;
    idle(4);
  endtask

  task automatic test_clean();
    int b0, b1, f0, f1, d1;
    logic [15:0] e;
    b0 = pv0; b1 = pv1; f0 = fs0; f1 = fs1; d1 = fd1;
    drive_frame(8, 8, -1);
    n_cmp += 5;
    if (pv0 - b0 != 0) begin
      n_bad++; $display("FAIL skip1_pv: got %0d want 0", pv0 - b0);
    end
    if (fs0 - f0 != 0) begin
      n_bad++; $display("FAIL skip1_fs: got %0d want 0", fs0 - f0);
    end
    if (fs1 - f1 != 1) begin
      n_bad++; $display("FAIL fw0_fs: got %0d want 1", fs1 - f1);
    end
    if (pv1 - b1 != 8) begin
      n_bad++; $display("FAIL fw0_pv: got %0d want 8", pv1 - b1);
    end
    if (log1[b1] !== 16'h0102) begin
      n_bad++; $display("FAIL fw0_first: got %h want 0102", log1[b1]);
    end
    n_cmp++;
    if (fd1 - d1 != 1) begin
      n_bad++; $display("FAIL fw0_fd: got %0d want 1", fd1 - d1);
    end
    drive_frame(8, 8, -1);
    n_cmp++;
    if (pv0 - b0 != 0) begin
      n_bad++; $display("FAIL skip2_pv: got %0d want 0", pv0 - b0);
    end
    b0 = pv0; f0 = fs0; d1 = fd0;
    b2_cyc = -1;
    drive_frame(8, 8, -1);
    n_cmp += 2;
    if (ok_d !== 1'b1) begin
      n_bad++; $display("FAIL clean3_ok: got %b want 1", ok_d);
    end
    if (lcyc[b0] - b2_cyc != 2) begin
      n_bad++; $display("FAIL latency: got %0d want 2", lcyc[b0] - b2_cyc);
    end
    drive_frame(8, 8, -1);
    n_cmp += 5;
    if (pv0 - b0 != 16) begin
      n_bad++; $display("FAIL clean_pv: got %0d want 16", pv0 - b0);
    end
    if (fs0 - f0 != 2) begin
      n_bad++; $display("FAIL clean_fs: got %0d want 2", fs0 - f0);
    end
    if (fd0 - d1 != 2) begin
      n_bad++; $display("FAIL clean_fd: got %0d want 2", fd0 - d1);
    end
    if (ok_d !== 1'b1) begin
      n_bad++; $display("FAIL clean4_ok: got %b want 1", ok_d);
    end
    if (err_d !== 1'b0) begin
      n_bad++; $display("FAIL clean4_err: got %b want 0", err_d);
    end
    for (int k = 0; k < 16; k++) begin
      e[15:8] = 8'((2 * (k % 8)) + 1);
      e[7:0]  = 8'((2 * (k % 8)) + 2);
      n_cmp++;
      if (log0[b0 + k] !== e) begin
        n_bad++;
        $display("FAIL clean_data[%0d]: got %h want %h", k, log0[b0 + k], e);
      end
    end
  endtask

  task automatic test_odd_line();
    int b0, d0;
    b0 = pv0; d0 = fd0;
    drive_frame(8, 7, -1);
    n_cmp += 5;
    if (pv0 - b0 != 7) begin
      n_bad++; $display("FAIL odd_pv: got %0d want 7", pv0 - b0);
    end
    if (fd0 - d0 != 1) begin
      n_bad++; $display("FAIL odd_fd: got %0d want 1", fd0 - d0);
    end
    if (ok_d !== 1'b0) begin
      n_bad++; $display("FAIL odd_ok: got %b want 0", ok_d);
    end
    if (err_d !== 1'b1) begin
      n_bad++; $display("FAIL odd_err: got %b want 1", err_d);
    end
    if (log0[b0 + 6] !== 16'h0D0E) begin
      n_bad++; $display("FAIL odd_last: got %h want 0D0E", log0[b0 + 6]);
    end
    b0 = pv0;
    drive_frame(8, 8, -1);
    n_cmp += 3;
    if (pv0 - b0 != 8) begin
      n_bad++; $display("FAIL recov_pv: got %0d want 8", pv0 - b0);
    end
    if (ok_d !== 1'b1) begin
      n_bad++; $display("FAIL recov_ok: got %b want 1", ok_d);
    end
    if (err_d !== 1'b0) begin
      n_bad++; $display("FAIL recov_err: got %b want 0", err_d);
    end
  endtask

  task automatic test_long_line();
    int b0;
    b0 = pv0;
    drive_frame(10, 8, -1);
    n_cmp += 5;
    if (pv0 - b0 != 8) begin
      n_bad++; $display("FAIL long_pv: got %0d want 8", pv0 - b0);
    end
    if (err_d !== 1'b1) begin
      n_bad++; $display("FAIL long_err: got %b want 1", err_d);
    end
    if (ok_d !== 1'b0) begin
      n_bad++; $display("FAIL long_ok: got %b want 0", ok_d);
    end
    if (log0[b0 + 7] !== 16'h0F10) begin
      n_bad++; $display("FAIL long_last: got %h want 0F10", log0[b0 + 7]);
    end
    if (ferr0 !== 1'b1) begin
      n_bad++; $display("FAIL long_sticky: got %b want 1", ferr0);
    end
  endtask

  task automatic test_reset_mid();
    int b0, f0, d0;
    b0 = pv0;
    open_frame();
    send_line(6, -1);
    idle(3);
    n_cmp++;
    if (pv0 - b0 != 3) begin
      n_bad++; $display("FAIL mid_pre_pv: got %0d want 3", pv0 - b0);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (pd0 !== 16'h0) begin
      n_bad++; $display("FAIL mid_rst_data: got %h want 0000", pd0);
    end
    if (fok0 !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_ok: got %b want 0", fok0);
    end
    if (pv0_o !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_pv: got %b want 0", pv0_o);
    end
    idle(2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    b0 = pv0; f0 = fs0; d0 = fd0;
    send_line(8, -1);
    close_frame();
    drive_frame(8, 8, -1);
    drive_frame(8, 8, -1);
    n_cmp += 3;
    if (pv0 - b0 != 0) begin
      n_bad++; $display("FAIL mid_skip_pv: got %0d want 0", pv0 - b0);
    end
    if (fd0 - d0 != 0) begin
      n_bad++; $display("FAIL mid_skip_fd: got %0d want 0", fd0 - d0);
    end
    if (fs0 - f0 != 0) begin
      n_bad++; $display("FAIL mid_skip_fs: got %0d want 0", fs0 - f0);
    end
    drive_frame(8, 8, -1);
    n_cmp += 3;
    if (pv0 - b0 != 8) begin
      n_bad++; $display("FAIL mid_resume_pv: got %0d want 8", pv0 - b0);
    end
    if (fs0 - f0 != 1) begin
      n_bad++; $display("FAIL mid_resume_fs: got %0d want 1", fs0 - f0);
    end
    if (ok_d !== 1'b1) begin
      n_bad++; $display("FAIL mid_resume_ok: got %b want 1", ok_d);
    end
  endtask

  task automatic test_en_drop();
    int b0, f0, d0;
    b0 = pv0; d0 = fd0;
    drive_frame(8, 8, 4);
    n_cmp += 3;
    if (pv0 - b0 != 1) begin
      n_bad++; $display("FAIL endrop_pv: got %0d want 1", pv0 - b0);
    end
    if (log0[b0] !== 16'h0102) begin
      n_bad++; $display("FAIL endrop_data: got %h want 0102", log0[b0]);
    end
    if (fd0 - d0 != 0) begin
      n_bad++; $display("FAIL endrop_fd: got %0d want 0", fd0 - d0);
    end
    en = 1'b1;
    idle(2);
    b0 = pv0; f0 = fs0;
    drive_frame(8, 8, -1);
    drive_frame(8, 8, -1);
    n_cmp += 2;
    if (pv0 - b0 != 0) begin
      n_bad++; $display("FAIL enback_skip_pv: got %0d want 0", pv0 - b0);
    end
    if (fs0 - f0 != 0) begin
      n_bad++; $display("FAIL enback_skip_fs: got %0d want 0", fs0 - f0);
    end
    drive_frame(8, 8, -1);
    n_cmp += 2;
    if (pv0 - b0 != 8) begin
      n_bad++; $display("FAIL enback_pv: got %0d want 8", pv0 - b0);
    end
    if (ok_d !== 1'b1) begin
      n_bad++; $display("FAIL enback_ok: got %b want 1", ok_d);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    vs    = 1'b1;
    hr    = 1'b0;
    din   = 8'd0;
    bval  = 8'd1;
    test_reset();
    test_clean();
    test_odd_line();
    test_long_line();
    test_reset_mid();
    test_en_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
